// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential multiplier and its carry-propagate adder.
package mult_pkg;

    localparam int unsigned SLICE_W    = 8;
    localparam int unsigned NUM_SLICES = 4;
    localparam int unsigned ACC_W      = 64;
    localparam int unsigned OP_W       = SLICE_W * NUM_SLICES;
    localparam int unsigned K_W        = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operands captured when a multiply is accepted
    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            sgn;
    } mult_ops_t;

    // True when every multiplier bit above slice k is a copy of ext
    function automatic logic slice_final(input logic [OP_W-1:0] b,
                                         input logic            ext,
                                         input logic [K_W-1:0]  k);
        logic [OP_W-1:0] upper_mask;
        upper_mask = {OP_W{1'b1}} << ((32'(k) + 32'd1) * SLICE_W);
        return ((b ^ {OP_W{ext}}) & upper_mask) == '0;
    endfunction

endpackage

// File: rtl/mult_cpa.sv
// 64-bit carry-propagate adder resolving the MAC slice's carry-save pair.
module mult_cpa
    import mult_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/mult_seq.sv
// Sequential 32x32 multiply(-accumulate) feeding an external 32x8 MAC slice one op_b byte per cycle.
// Define MULT_EARLY_TERM_EN to stop once the remaining multiplier bytes are pure sign extension.
module mult_seq
    import mult_pkg::*;
(
    input  logic               nGCLK,
    input  logic               nRESET,
    input  logic               start,
    input  logic [OP_W-1:0]    op_a,
    input  logic [OP_W-1:0]    op_b,
    input  logic [ACC_W-1:0]   acc_in,
    input  logic               sign,
    input  logic               accum,
    output logic               busy,
    output logic               done,
    output logic [ACC_W-1:0]   result,
    output logic [OP_W:0]      ma_op1,
    output logic [SLICE_W+1:0] ma_op2,
    output logic               ma_op2_1,
    output logic [K_W-1:0]     ma_slice,
    output logic               ma_msb,
    output logic [ACC_W-1:0]   ma_acc,
    input  logic [ACC_W-1:0]   ma_sum1,
    input  logic [ACC_W-1:0]   ma_sum2
);

    state_e             state_q, state_d;
    mult_ops_t          ops_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   cpa_sum;
    logic [ACC_W-1:0]   result_q;
    logic [K_W-1:0]     k_q;
    logic               busy_q;
    logic               done_q;
    logic               ext_c;
    logic               last_c;

    assign ext_c = ops_q.sgn & ops_q.b[OP_W-1];

`ifdef MULT_EARLY_TERM_EN
    assign last_c = slice_final(ops_q.b, ext_c, k_q);
`else
    assign last_c = (k_q == K_W'(NUM_SLICES - 1));
`endif

    mult_cpa u_cpa (
        .a   (ma_sum1),
        .b   (ma_sum2),
        .sum (cpa_sum)
    );

    // State register
    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and MAC slice drive; slice inputs are quiet outside CALC
    always_comb begin
        state_d  = state_q;
        ma_op1   = '0;
        ma_op2   = '0;
        ma_op2_1 = 1'b0;
        ma_slice = '0;
        ma_msb   = 1'b0;
        ma_acc   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                ma_op1   = {ops_q.sgn & ops_q.a[OP_W-1], ops_q.a};
                ma_op2   = {ext_c, ext_c, ops_q.b[{k_q, 3'b000} +: SLICE_W]};
                ma_op2_1 = (k_q == '0) ? 1'b0 : ops_q.b[{k_q, 3'b000} - 5'd1];
                ma_slice = k_q;
                ma_msb   = last_c;
                ma_acc   = acc_q;
                if (last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, accumulator, slice counter and registered status
    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            ops_q    <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_d == DONE);
            if (state_q == IDLE && start) begin
                ops_q <= '{a: op_a, b: op_b, sgn: sign};
                acc_q <= accum ? acc_in : '0;
                k_q   <= '0;
            end else if (state_q == CALC) begin
                acc_q <= cpa_sum;
                k_q   <= k_q + K_W'(1);
            end
            if (state_q == CALC && state_d == DONE) begin
                result_q <= cpa_sum;
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq with a behavioural 32x8 Booth MAC slice on the ma_* ports.
// Honours MULT_EARLY_TERM_EN for expected latency.
module tb_mult_seq;

    logic        nGCLK  = 1'b0;
    logic        nRESET = 1'b0;
    logic        start  = 1'b0;
    logic [31:0] op_a   = '0;
    logic [31:0] op_b   = '0;
    logic [63:0] acc_in = '0;
    logic        sign   = 1'b0;
    logic        accum  = 1'b0;
    logic        busy, done;
    logic [63:0] result;
    logic [32:0] ma_op1;
    logic [9:0]  ma_op2;
    logic        ma_op2_1;
    logic [1:0]  ma_slice;
    logic        ma_msb;
    logic [63:0] ma_acc;
    logic [63:0] ma_sum1, ma_sum2;
    logic [63:0] mac_total;
    logic [63:0] split = '0;

    int n_checks = 0;
    int n_fail   = 0;

    mult_seq dut (
        .nGCLK    (nGCLK),
        .nRESET   (nRESET),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .acc_in   (acc_in),
        .sign     (sign),
        .accum    (accum),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ma_op1   (ma_op1),
        .ma_op2   (ma_op2),
        .ma_op2_1 (ma_op2_1),
        .ma_slice (ma_slice),
        .ma_msb   (ma_msb),
        .ma_acc   (ma_acc),
        .ma_sum1  (ma_sum1),
        .ma_sum2  (ma_sum2)
    );

    always #5 nGCLK = ~nGCLK;

    // Booth slice: digits over the low byte plus overlap bit; the final slice also takes the two ext bits
    function automatic logic [63:0] mac_model(input logic [32:0] op1, input logic [9:0] op2,
                                              input logic ov, input logic msb,
                                              input logic [1:0] sl, input logic [63:0] acc);
        longint a, m, p;
        logic signed [9:0] s10;
        logic signed [7:0] s8;
        a   = longint'($signed(op1));
        s10 = op2;
        s8  = op2[7:0];
        if (msb) m = longint'(s10);
        else     m = longint'(s8);
        if (ov) m = m + 64'sd1;
        p = a * m;
        return acc + (64'(p) << (8 * sl));
    endfunction

    // Return the slice result as a randomly split carry-save pair
    always @(negedge nGCLK) split = {$urandom, $urandom};
    always_comb begin
        mac_total = mac_model(ma_op1, ma_op2, ma_op2_1, ma_msb, ma_slice, ma_acc);
        ma_sum2   = split;
        ma_sum1   = mac_total - split;
    end

    function automatic logic [63:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn, input logic acm,
                                               input logic [63:0] acc);
        logic [63:0] p;
        if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
        else     p = {32'b0, a} * {32'b0, b};
        return p + (acm ? acc : 64'd0);
    endfunction

    // Cycles from start to done: shortest byte count whose value range holds op_b
    function automatic int ref_cycles(input logic [31:0] b, input logic sgn);
        longint bv, lim;
        int kf;
        bv = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        kf = 3;
        for (int k = 3; k >= 0; k--) begin
            lim = longint'(1) << (8 * k + 8);
            if (bv >= -lim && bv < lim) kf = k;
        end
`ifdef MULT_EARLY_TERM_EN
        return kf + 2;
`else
        return (kf >= 0) ? 5 : 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic acm, input logic [63:0] acc, input logic pulse,
                          input string tag);
        logic [63:0] exp_r;
        int exp_c, cyc, extra;
        exp_r = ref_result(a, b, sgn, acm, acc);
        exp_c = ref_cycles(b, sgn);
        @(posedge nGCLK); #1;
        op_a = a; op_b = b; sign = sgn; accum = acm; acc_in = acc; start = 1'b1;
        @(posedge nGCLK); #1;
        cyc = 1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; sign = 1'($urandom); accum = 1'($urandom);
        acc_in = {$urandom, $urandom};
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && cyc < 20) begin
            start = pulse && (cyc <= 4);
            if (start) begin
                op_a = $urandom; op_b = $urandom;
            end
            @(posedge nGCLK); #1;
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(exp_c));
        check({tag, "_res"}, result, exp_r);
        start = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge nGCLK); #1;
            if (done === 1'b1) extra++;
        end
        check({tag, "_extra_done"}, 64'(extra), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_hold"}, result, exp_r);
    endtask

    task automatic reset_mid_calc();
        int extra;
        @(posedge nGCLK); #1;
        op_a = 32'h1234_5678; op_b = 32'h5A00_00C3; sign = 1'b0; accum = 1'b0; start = 1'b1;
        @(posedge nGCLK); #1;
        start = 1'b0;
        @(posedge nGCLK); #1;
        @(posedge nGCLK); #1;
        nRESET = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_ma_acc", ma_acc, 64'd0);
        repeat (2) @(negedge nGCLK);
        nRESET = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge nGCLK); #1;
            if (done === 1'b1) extra++;
        end
        check("rst_no_done", 64'(extra), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic sgn;
        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_ma_ctl", {17'b0, ma_op1, ma_op2, ma_op2_1, ma_slice, ma_msb}, 64'd0);
        check("reset_ma_acc", ma_acc, 64'd0);
        repeat (2) @(negedge nGCLK);
        nRESET = 1'b1;

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'd0, 1'b0, "umax");
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 64'h10, 1'b0, "neg1x2acc");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 64'd0, 1'b0, "minsq");
        run_op(32'h0000_0000, 32'hFFFF_FF00, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, "zero_a");
        run_op($urandom, {8'h40, 24'($urandom)}, 1'($urandom), 1'b1, {$urandom, $urandom},
               1'b1, "restart");
        reset_mid_calc();
        run_op(32'h0001_0003, 32'h0000_0080, 1'b0, 1'b0, 64'd0, 1'b0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = $urandom >> (8 * $urandom_range(0, 3));
            sgn = 1'($urandom);
            if (sgn && $urandom_range(0, 1) == 1) b = ~b;
            run_op(a, b, sgn, 1'($urandom), {$urandom, $urandom}, 1'b0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 nGCLK  input  1  single clock; all state changes on rising edge.
REQ-002 nRESET  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle request to begin a multiply; sampled only in IDLE.
REQ-004 op_a  input  32  multiplicand.
REQ-005 op_b  input  32  multiplier, consumed one byte per slice.
REQ-006 acc_in  input  64  accumulate addend.
REQ-007 sign  input  1  1 selects signed operands; 0 selects unsigned operands.
REQ-008 accum  input  1  1 adds acc_in to the product; 0 adds zero.
REQ-009 busy  output  1  high while a multiply is in flight.
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 result  output  64  final product or accumulated product.
REQ-012 ma_op1  output  33  multiplicand to the MAC slice: {sign&op_a[31], op_a}.
REQ-013 ma_op2  output  10  multiplier slice: {ext, ext, op_b byte k}; ext = sign&op_b[31].
REQ-014 ma_op2_1  output  1  Booth overlap bit: op_b[8k-1], or 0 when k=0.
REQ-015 ma_slice  output  2  current byte index k.
REQ-016 ma_msb  output  1  high on the final slice processed.
REQ-017 ma_acc  output  64  running accumulator fed to the MAC slice.
REQ-018 ma_sum1, ma_sum2  input  64 each  carry-save outputs returned by the MAC slice.

Function
REQ-019 States are IDLE, CALC and DONE; reset enters IDLE.
REQ-020 Transition IDLE->CALC occurs on start=1: op_a, op_b and sign are latched, acc_reg is loaded with acc_in if accum=1 (else 0), and k=0.
REQ-021 In CALC, each cycle: acc_reg <= ma_sum1 + ma_sum2 (64-bit, carry out discarded), k <= k+1, and ma_* outputs are combinational from the latched operands, k and acc_reg.
REQ-022 On the cycle with ma_msb=1, CALC->DONE; ma_msb is 1 at k=3 unless REQ-033 applies.
REQ-023 DONE lasts exactly one cycle with done=1 and result=acc_reg, then returns to IDLE.
REQ-024 result holds its value after DONE until the next DONE.
REQ-025 busy=1 in CALC and DONE; start while busy=1 is ignored.
REQ-026 Latency without early termination: start at cycle 0 -> done at cycle 5.
REQ-027 start coincident with done is ignored; start is accepted only from IDLE on the following cycle.
REQ-028 ma_op1, ma_op2, ma_op2_1, ma_slice, ma_msb and ma_acc drive 0 in IDLE.

Reset
REQ-029 nRESET low immediately forces IDLE, busy=0, done=0, result=0, acc_reg=0, k=0 and all latched operands to 0.
REQ-030 Reset asserted mid-CALC aborts the operation; no done is produced and the partial result is discarded.

Configuration
REQ-031 The macro MULT_EARLY_TERM_EN enables early termination.
REQ-032 Without MULT_EARLY_TERM_EN, CALC always runs 4 cycles (k=0..3).
REQ-033 With MULT_EARLY_TERM_EN, slice k is final (ma_msb=1) when op_b[31:8k+8] all equal ext; with ext=0 (unsigned or positive op_b) this is all zero. Latency is then k+2 cycles, minimum 2.

Structure
REQ-034 Shared package mult_pkg holds the state enum (IDLE/CALC/DONE), SLICE_W=8, NUM_SLICES=4 and ACC_W=64.
REQ-035 The 64-bit carry-propagate adder is the sub-module mult_cpa (inputs a, b; output sum).

Verification
REQ-036 Bench instantiates mult_seq with the existing 32x8 MAC slice connected on the ma_* ports, with MULT_EARLY_TERM_EN both defined and undefined.
REQ-037 Unsigned: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, accum=0 -> result=0xFFFFFFFE00000001, done at cycle 5.
REQ-038 Signed: op_a=0xFFFFFFFF (-1), op_b=0x00000002, accum=1, acc_in=0x10 -> result=0x000000000000000E; with MULT_EARLY_TERM_EN, done at cycle 2.
REQ-039 Signed: op_a=0x80000000, op_b=0x80000000 -> result=0x4000000000000000, 4 slices in both builds.
REQ-040 start pulsed again at cycles 1-4 -> ignored; exactly one done; result unaffected.
REQ-041 nRESET asserted at cycle 3 of a CALC -> busy=0 and result=0 immediately; no done; the next start completes correctly.
